// File: rtl/ppu_pkg.sv
// ppu_pkg: shared constants and helpers for the PPU fetch generator.
//   Dot/line landmarks, bus base addresses, loopy-v field offsets, the access
//   kind enum and the attribute-address helper.
package ppu_pkg;

    localparam logic [8:0] DOT_LAST   = 9'd340;
    localparam logic [8:0] LINE_PRE   = 9'd261;
    localparam logic [8:0] VIS_LAST   = 9'd239;
    localparam logic [8:0] BG_LAST    = 9'd256;
    localparam logic [8:0] SPR_FIRST  = 9'd257;
    localparam logic [8:0] SPR_LAST   = 9'd320;
    localparam logic [8:0] PREF_FIRST = 9'd321;
    localparam logic [8:0] PREF_LAST  = 9'd336;

    localparam logic [13:0] NT_BASE = 14'h2000;
    localparam logic [13:0] AT_BASE = 14'h23C0;

    // loopy v/t field offsets
    localparam int V_CX_LSB = 0;
    localparam int V_CY_LSB = 5;
    localparam int V_NTX    = 10;
    localparam int V_NTY    = 11;
    localparam int V_FY_LSB = 12;

    // Order of the first four matches the background group phase ph[2:1].
    typedef enum logic [2:0] {
        ACC_NT, ACC_AT, ACC_BLO, ACC_BHI, ACC_SLO, ACC_SHI
    } acc_e;

    function automatic logic [13:0] at_addr(input logic [14:0] v);
        return AT_BASE | {2'b00, v[V_NTY:V_NTX], 4'b0000, v[9:7], v[4:2]};
    endfunction

endpackage

// File: rtl/ppu_vaddr.sv
// ppu_vaddr: the loopy current-VRAM-address register v.
//   clk, rst_n (sync, active low, loads t_init), ce (dot enable),
//   t_init (source for copies), inc_x / inc_y / copy_h / copy_v (strobes for
//   the dot being entered), v (current value).
module ppu_vaddr
    import ppu_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ce,
    input  logic [14:0] t_init,
    input  logic        inc_x,
    input  logic        inc_y,
    input  logic        copy_h,
    input  logic        copy_v,
    output logic [14:0] v
);

    logic [14:0] v_q, v_d;

    // inc_x and inc_y touch disjoint fields, so both may apply on one dot.
    always_comb begin
        v_d = v_q;
        if (inc_x) begin
            if (v_q[4:0] == 5'd31) begin
                v_d[4:0]   = 5'd0;
                v_d[V_NTX] = ~v_q[V_NTX];
            end else begin
                v_d[4:0] = v_q[4:0] + 5'd1;
            end
        end
        if (inc_y) begin
            if (v_q[14:12] != 3'd7) begin
                v_d[14:12] = v_q[14:12] + 3'd1;
            end else begin
                v_d[14:12] = 3'd0;
                if (v_q[9:5] == 5'd29) begin
                    v_d[9:5]   = 5'd0;
                    v_d[V_NTY] = ~v_q[V_NTY];
                end else if (v_q[9:5] == 5'd31) begin
                    v_d[9:5] = 5'd0;          // attribute-row overflow: no NT toggle
                end else begin
                    v_d[9:5] = v_q[9:5] + 5'd1;
                end
            end
        end
        if (copy_h) begin
            v_d[V_NTX] = t_init[V_NTX];
            v_d[4:0]   = t_init[4:0];
        end
        if (copy_v) begin
            v_d[14:11] = t_init[14:11];
            v_d[9:5]   = t_init[9:5];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)  v_q <= t_init;
        else if (ce) v_q <= v_d;
    end

    assign v = v_q;

endmodule

// File: rtl/ppu_fetch_gen.sv
// ppu_fetch_gen: cycle-accurate 2C02 background/sprite fetch sequencer.
//   Inputs : clk, map_rst_n (sync, active low), dot_ce, render_en, t_init,
//            bg_pt, spr_pt, ppu_dat (tile index from NT reads).
//   Outputs: ppu_addr / ppu_oe (registered bus), ppu_we (tied 1),
//            dot, line, frame_odd.
// All decode is done for the dot being entered (dot_d), so the registered
// outputs show dot N's bus state for exactly the duration of dot N.
module ppu_fetch_gen
    import ppu_pkg::*;
#(
    parameter bit ODD_SKIP = 1'b1
) (
    input  logic        clk,
    input  logic        map_rst_n,
    input  logic        dot_ce,
    input  logic        render_en,
    input  logic [14:0] t_init,
    input  logic        bg_pt,
    input  logic        spr_pt,
    input  logic [7:0]  ppu_dat,
    output logic [13:0] ppu_addr,
    output logic        ppu_oe,
    output logic        ppu_we,
    output logic [8:0]  dot,
    output logic [8:0]  line,
    output logic        frame_odd
);

    logic [8:0]  dot_q, dot_d, line_q, line_d;
    logic        odd_q, odd_d, rend_q, rend_d;
    logic [13:0] addr_q, addr_d, fetch_addr;
    logic        oe_q, oe_d, nt_rd_q, nt_rd_d;
    logic [7:0]  tile_q, tile_d;
    logic [14:0] v;
    logic [2:0]  ph;
    logic        in_bg, in_spr, in_dum, fetch, active;
    acc_e        kind;

    // Position of the next dot, including the odd-frame pre-render skip.
    always_comb begin
        dot_d  = dot_q + 9'd1;
        line_d = line_q;
        odd_d  = odd_q;
        if (ODD_SKIP && rend_q && odd_q && line_q == LINE_PRE && dot_q == DOT_LAST - 9'd1) begin
            dot_d  = 9'd0;
            line_d = 9'd0;
            odd_d  = ~odd_q;
        end else if (dot_q == DOT_LAST) begin
            dot_d = 9'd0;
            if (line_q == LINE_PRE) begin
                line_d = 9'd0;
                odd_d  = ~odd_q;
            end else begin
                line_d = line_q + 9'd1;
            end
        end
    end

    // render_en is only looked at when a line starts.
    assign rend_d = (dot_d == 9'd0) ? render_en : rend_q;
    assign active = rend_d && (line_d <= VIS_LAST || line_d == LINE_PRE);

    assign ph     = dot_d[2:0] - 3'd1;   // position inside the 8-dot group
    assign in_bg  = (dot_d >= 9'd1 && dot_d <= BG_LAST) || (dot_d >= PREF_FIRST && dot_d <= PREF_LAST);
    assign in_spr = dot_d >= SPR_FIRST && dot_d <= SPR_LAST;
    assign in_dum = dot_d > PREF_LAST && dot_d <= DOT_LAST;

    always_comb begin
        kind  = ACC_NT;
        fetch = 1'b0;
        if (in_bg) begin
            fetch = 1'b1;
            kind  = acc_e'({1'b0, ph[2:1]});
        end else if (in_spr) begin
            fetch = 1'b1;
            if (ph[2]) kind = ph[1] ? ACC_SHI : ACC_SLO;
        end else if (in_dum) begin
            fetch = 1'b1;
        end
    end

    always_comb begin
        case (kind)
            ACC_AT:  fetch_addr = at_addr(v);
            ACC_BLO: fetch_addr = {1'b0, bg_pt, tile_q, 1'b0, v[14:12]};
            ACC_BHI: fetch_addr = {1'b0, bg_pt, tile_q, 1'b1, v[14:12]};
            ACC_SLO: fetch_addr = {1'b0, spr_pt, 8'hFF, 4'h0};   // hidden sprite, row 0
            ACC_SHI: fetch_addr = {1'b0, spr_pt, 8'hFF, 4'h8};
            default: fetch_addr = NT_BASE | {2'b00, v[11:0]};
        endcase
    end

    // Odd dot drives the address, even dot pulls /RD low with address held.
    always_comb begin
        addr_d  = addr_q;
        oe_d    = 1'b1;
        nt_rd_d = 1'b0;
        if (active && fetch) begin
            if (!ph[0]) begin
                addr_d = fetch_addr;
            end else begin
                oe_d    = 1'b0;
                nt_rd_d = (kind == ACC_NT);
            end
        end
        // Latch the tile on the edge that ends an NT read dot.
        tile_d = nt_rd_q ? ppu_dat : tile_q;
    end

    ppu_vaddr u_vaddr (
        .clk    (clk),
        .rst_n  (map_rst_n),
        .ce     (dot_ce),
        .t_init (t_init),
        .inc_x  (active && ((dot_d >= 9'd8 && dot_d <= BG_LAST && dot_d[2:0] == 3'd0) ||
                            dot_d == 9'd328 || dot_d == PREF_LAST)),
        .inc_y  (active && dot_d == BG_LAST),
        .copy_h (active && dot_d == SPR_FIRST),
        .copy_v (active && line_d == LINE_PRE && dot_d >= 9'd280 && dot_d <= 9'd304),
        .v      (v)
    );

    always_ff @(posedge clk) begin
        if (!map_rst_n) begin
            dot_q   <= 9'd0;
            line_q  <= LINE_PRE;
            odd_q   <= 1'b0;
            rend_q  <= render_en;
            addr_q  <= 14'd0;
            oe_q    <= 1'b1;
            nt_rd_q <= 1'b0;
            tile_q  <= 8'd0;
        end else if (dot_ce) begin
            dot_q   <= dot_d;
            line_q  <= line_d;
            odd_q   <= odd_d;
            rend_q  <= rend_d;
            addr_q  <= addr_d;
            oe_q    <= oe_d;
            nt_rd_q <= nt_rd_d;
            tile_q  <= tile_d;
        end
    end

    assign ppu_addr  = addr_q;
    assign ppu_oe    = oe_q;
    assign ppu_we    = 1'b1;
    assign dot       = dot_q;
    assign line      = line_q;
    assign frame_odd = odd_q;

endmodule

// File: tb/tb_ppu_fetch_gen.sv
module tb_ppu_fetch_gen;

    logic        clk = 1'b0;
    logic        map_rst_n = 1'b0;
    logic        dot_ce = 1'b1;
    logic        render_en = 1'b1;
    logic [14:0] t_init = 15'h0;
    logic        bg_pt = 1'b0;
    logic        spr_pt = 1'b0;
    logic [7:0]  ppu_dat = 8'h24;
    logic [13:0] ppu_addr;
    logic        ppu_oe, ppu_we, frame_odd;
    logic [8:0]  dot, line;

    // second instance with rendering held off, used for the frame-length check
    logic        off_ren = 1'b0;
    logic [13:0] off_addr;
    logic        off_oe, off_we, off_odd;
    logic [8:0]  off_dot, off_line;

    int n_vec = 0;
    int n_err = 0;
    bit off_bad = 1'b0;

    typedef struct {
        int          ln;
        int          dt;
        logic [13:0] addr;
        bit          chk_a;
        logic        oe;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    ppu_fetch_gen #(.ODD_SKIP(1'b1)) dut (
        .clk(clk), .map_rst_n(map_rst_n), .dot_ce(dot_ce), .render_en(render_en),
        .t_init(t_init), .bg_pt(bg_pt), .spr_pt(spr_pt), .ppu_dat(ppu_dat),
        .ppu_addr(ppu_addr), .ppu_oe(ppu_oe), .ppu_we(ppu_we),
        .dot(dot), .line(line), .frame_odd(frame_odd)
    );

    ppu_fetch_gen #(.ODD_SKIP(1'b1)) u_off (
        .clk(clk), .map_rst_n(map_rst_n), .dot_ce(dot_ce), .render_en(off_ren),
        .t_init(t_init), .bg_pt(bg_pt), .spr_pt(spr_pt), .ppu_dat(ppu_dat),
        .ppu_addr(off_addr), .ppu_oe(off_oe), .ppu_we(off_we),
        .dot(off_dot), .line(off_line), .frame_odd(off_odd)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        assert (got === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic push(input int ln, input int dt, input logic [13:0] a, input bit ca, input logic oe);
        exp_t e;
        e.ln = ln; e.dt = dt; e.addr = a; e.chk_a = ca; e.oe = oe;
        sb.push_back(e);
    endtask

    // One clock, sampled on the falling edge; pops the scoreboard when the
    // DUT reaches the position of the oldest expectation.
    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (map_rst_n && (off_oe !== 1'b1 || off_addr !== 14'h0)) off_bad = 1'b1;
        if (map_rst_n && sb.size() > 0 && int'(line) == sb[0].ln && int'(dot) == sb[0].dt) begin
            e = sb.pop_front();
            chk($sformatf("oe L%0d D%0d", e.ln, e.dt), 32'(ppu_oe), 32'(e.oe));
            if (e.chk_a)
                chk($sformatf("addr L%0d D%0d", e.ln, e.dt), 32'(ppu_addr), 32'(e.addr));
        end
    endtask

    task automatic drain(input int budget, input string tag);
        int k = 0;
        while (sb.size() > 0 && k < budget) begin tick(); k++; end
        chk(tag, 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic wait_pos(input int ln, input int dt, input int budget);
        int k = 0;
        while (!(int'(line) == ln && int'(dot) == dt) && k < budget) begin tick(); k++; end
        chk($sformatf("reach L%0d D%0d", ln, dt), 32'(int'(line) * 1000 + int'(dot)), 32'(ln * 1000 + dt));
    endtask

    initial begin
        int n, len_on, len_off, pre_on, pre_off;
        bit d_on, d_off;

        // ---- Y wrap: fine_y=7, coarse_y=29 ----
        t_init = 15'h73A0;
        tick(); tick();
        chk("rst line", 32'(line), 32'd261);
        chk("rst dot", 32'(dot), 32'd0);
        chk("rst oe", 32'(ppu_oe), 32'd1);
        chk("rst addr", 32'(ppu_addr), 32'd0);
        chk("we", 32'(ppu_we), 32'd1);
        push(0, 1,   14'h23A2, 1, 1'b1);
        push(0, 3,   14'h23F8, 1, 1'b1);
        push(0, 5,   14'h0247, 1, 1'b1);
        push(0, 257, 14'h2C02, 1, 1'b1);
        push(0, 259, 14'h2800, 1, 1'b1);
        push(0, 325, 14'h0240, 1, 1'b1);
        map_rst_n = 1'b1;
        drain(1000, "ywrap drain");
        // mid-line render_en drop: line 0 finishes, line 1 is idle
        render_en = 1'b0;
        push(0, 337, 14'h2802, 1, 1'b1);
        push(0, 340, 14'h2802, 1, 1'b0);
        push(1, 2,   14'h2802, 1, 1'b1);
        push(1, 5,   14'h2802, 1, 1'b1);
        drain(200, "render off drain");
        // dot_ce low freezes everything
        wait_pos(1, 50, 400);
        dot_ce = 1'b0;
        repeat (4) tick();
        chk("hold dot", 32'(dot), 32'd50);
        chk("hold line", 32'(line), 32'd1);
        dot_ce = 1'b1;
        render_en = 1'b1;
        // reset mid-access (dot 100 is an AT read dot)
        wait_pos(10, 100, 4000);
        chk("L10 D100 oe", 32'(ppu_oe), 32'd0);
        map_rst_n = 1'b0;
        tick();
        chk("midrst line", 32'(line), 32'd261);
        chk("midrst dot", 32'(dot), 32'd0);
        chk("midrst oe", 32'(ppu_oe), 32'd1);
        chk("midrst addr", 32'(ppu_addr), 32'd0);

        // ---- Fetch pattern + frame lengths, t_init=0, spr_pt=1 ----
        t_init = 15'h0;
        spr_pt = 1'b1;
        tick();
        push(261, 1, 14'h2000, 1, 1'b1);
        push(261, 2, 14'h0000, 0, 1'b0);
        push(261, 3, 14'h23C0, 1, 1'b1);
        push(261, 5, 14'h0240, 1, 1'b1);
        push(261, 7, 14'h0248, 1, 1'b1);
        for (int g = 0; g < 8; g++) begin
            push(261, 257 + 8 * g, (g == 0) ? 14'h2400 : 14'h2000, 1, 1'b1);
            push(261, 259 + 8 * g, 14'h2000, 1, 1'b1);
            push(261, 261 + 8 * g, 14'h1FF0, 1, 1'b1);
            push(261, 263 + 8 * g, 14'h1FF8, 1, 1'b1);
        end
        push(261, 337, 14'h2002, 1, 1'b1);
        push(261, 338, 14'h2002, 1, 1'b0);
        push(261, 339, 14'h2002, 1, 1'b1);
        push(261, 340, 14'h2002, 1, 1'b0);
        push(0, 0,   14'h2002, 1, 1'b1);
        push(0, 1,   14'h2002, 1, 1'b1);
        push(0, 3,   14'h23C0, 1, 1'b1);
        push(0, 5,   14'h0240, 1, 1'b1);
        push(250, 5, 14'h2802, 1, 1'b1);
        off_bad = 1'b0;
        map_rst_n = 1'b1;

        n = 0; d_on = 0; d_off = 0; len_on = 0; len_off = 0;
        while ((!d_on || !d_off) && n < 90000) begin
            tick(); n++;
            if (!d_on  && line == 9'd261 && dot == 9'd0)         begin len_on  = n; d_on  = 1; end
            if (!d_off && off_line == 9'd261 && off_dot == 9'd0) begin len_off = n; d_off = 1; end
        end
        chk("frame1 len on", 32'(len_on), 32'd89342);
        chk("frame1 len off", 32'(len_off), 32'd89342);
        chk("sb empty", 32'(sb.size()), 32'd0);
        sb.delete();

        n = 0; d_on = 0; d_off = 0; pre_on = 0; pre_off = 0;
        while ((!d_on || !d_off) && n < 1000) begin
            tick(); n++;
            if (!d_on  && line == 9'd0 && dot == 9'd0)         begin pre_on  = n; d_on  = 1; end
            if (!d_off && off_line == 9'd0 && off_dot == 9'd0) begin pre_off = n; d_off = 1; end
        end
        chk("odd prerender len on", 32'(pre_on), 32'd340);
        chk("odd prerender len off", 32'(pre_off), 32'd341);
        chk("frame2 len on", 32'(len_on - 341 + pre_on), 32'd89341);
        chk("render off bus idle", 32'(off_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
